npu_line_store: RTL and testbench

//  Write-side receiver for the NPU ALU layer-result port. Captures (en_w, w_line, data) into one register per

---
 rtl/npu_line_store_pkg.sv | 26 ++
 rtl/npu_byte_serializer.sv | 69 ++++++
 rtl/npu_line_store.sv | 102 ++++++++++
 tb/tb_npu_line_store.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_line_store_pkg.sv
// Shared definitions for the NPU line store.
//  - reset polarity constant
//  - feature-map line codes carried on w_line_i
//  - byte-serializer FSM state encodings
//  - line_code_ok(): true for codes that select a stored line
package npu_line_store_pkg;

  localparam logic RST_ACTIVE = 1'b1;

  localparam int NUM_LINES = 5;

  localparam logic [3:0] IMG_S2_LINE = 4'd1;
  localparam logic [3:0] IMG_C3_LINE = 4'd2;
  localparam logic [3:0] IMG_S4_LINE = 4'd3;
  localparam logic [3:0] IMG_C5_LINE = 4'd4;
  localparam logic [3:0] RESULT_LINE = 4'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic logic line_code_ok(input logic [3:0] code);
    return (code >= IMG_S2_LINE) && (code <= RESULT_LINE);
  endfunction

endpackage

// File: rtl/npu_byte_serializer.sv
// Streams a RES_W-bit line out one byte per cycle, byte 0 (bits 7:0) first.
// The line is snapshotted into a shadow register on rd_start_i so later
// writes to the source line do not disturb a stream in flight.
// Ports:
//  clk_i, rst_i   clock, async active-high reset
//  rd_start_i     start request (accepted in IDLE only)
//  line_i         RES_W-bit line to snapshot
//  result_o       current byte (0 when byte_vld_o=0)
//  byte_idx_o     index of result_o (0 when byte_vld_o=0)
//  byte_vld_o     byte valid
//  rd_done_o      one-cycle pulse after the last byte
//  rd_busy_o      stream in progress
//  start_err_o    rd_start_i seen while streaming (one-cycle flag)
module npu_byte_serializer
  import npu_line_store_pkg::*;
#(
  parameter int RES_W = 80,
  localparam int NB    = RES_W / 8,
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_start_i,
  input  logic [RES_W-1:0] line_i,
  output logic [7:0]       result_o,
  output logic [IDX_W-1:0] byte_idx_o,
  output logic             byte_vld_o,
  output logic             rd_done_o,
  output logic             rd_busy_o,
  output logic             start_err_o
);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [RES_W-1:0] shadow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RST_ACTIVE) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shadow <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rd_start_i) begin
          shadow <= line_i;
          idx    <= '0;
          state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (idx == IDX_W'(NB - 1)) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;  // DONE lasts one cycle; start ignored
      endcase
    end
  end

  assign byte_vld_o  = (state == ST_STREAM);
  assign rd_busy_o   = (state == ST_STREAM);
  assign rd_done_o   = (state == ST_DONE);
  assign start_err_o = (state == ST_STREAM) && rd_start_i;
  assign result_o    = byte_vld_o ? shadow[8*int'(idx) +: 8] : 8'h00;
  assign byte_idx_o  = byte_vld_o ? idx : '0;

endmodule

// File: rtl/npu_line_store.sv
// Write-side receiver for the NPU ALU layer-result port. Holds one register
// per feature-map line, drives the stored maps to the next layer and
// serialises the RESULT line byte-by-byte for LRMOVE.
// Ports:
//  clk_i, rst_i        clock, async active-high reset
//  en_w_i, w_line_i    write strobe and target line code
//  img*_data_i         per-line write data; result_data_i for RESULT
//  clr_i               sync clear of lines, valid flags and error
//  rd_start_i          start RESULT byte stream
//  img28/14/10/5_o     stored lines
//  line_vld_o          [0]=S2 .. [4]=RESULT written since reset/clr
//  result_o, byte_idx_o, byte_vld_o, rd_done_o, rd_busy_o  byte stream
//  err_o               sticky: bad line code or rd_start while busy
module npu_line_store
  import npu_line_store_pkg::*;
#(
  parameter int S2_W  = 6272,
  parameter int C3_W  = 3136,
  parameter int S4_W  = 3200,
  parameter int C5_W  = 800,
  parameter int RES_W = 80,
  localparam int IDX_W = (RES_W / 8 > 1) ? $clog2(RES_W / 8) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_w_i,
  input  logic [3:0]           w_line_i,
  input  logic [S2_W-1:0]      img28_data_i,
  input  logic [C3_W-1:0]      img14_data_i,
  input  logic [S4_W-1:0]      img10_data_i,
  input  logic [C5_W-1:0]      img5_data_i,
  input  logic [RES_W-1:0]     result_data_i,
  input  logic                 clr_i,
  input  logic                 rd_start_i,
  output logic [S2_W-1:0]      img28_o,
  output logic [C3_W-1:0]      img14_o,
  output logic [S4_W-1:0]      img10_o,
  output logic [C5_W-1:0]      img5_o,
  output logic [NUM_LINES-1:0] line_vld_o,
  output logic [7:0]           result_o,
  output logic [IDX_W-1:0]     byte_idx_o,
  output logic                 byte_vld_o,
  output logic                 rd_done_o,
  output logic                 rd_busy_o,
  output logic                 err_o
);

  logic [RES_W-1:0] res_q;
  logic             start_err;

  // clr_i takes priority over a write in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RST_ACTIVE) begin
      img28_o    <= '0;
      img14_o    <= '0;
      img10_o    <= '0;
      img5_o     <= '0;
      res_q      <= '0;
      line_vld_o <= '0;
    end else if (clr_i) begin
      img28_o    <= '0;
      img14_o    <= '0;
      img10_o    <= '0;
      img5_o     <= '0;
      res_q      <= '0;
      line_vld_o <= '0;
    end else if (en_w_i) begin
      case (w_line_i)
        IMG_S2_LINE: begin img28_o <= img28_data_i;  line_vld_o[0] <= 1'b1; end
        IMG_C3_LINE: begin img14_o <= img14_data_i;  line_vld_o[1] <= 1'b1; end
        IMG_S4_LINE: begin img10_o <= img10_data_i;  line_vld_o[2] <= 1'b1; end
        IMG_C5_LINE: begin img5_o  <= img5_data_i;   line_vld_o[3] <= 1'b1; end
        RESULT_LINE: begin res_q   <= result_data_i; line_vld_o[4] <= 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RST_ACTIVE)
      err_o <= 1'b0;
    else if (clr_i)
      err_o <= 1'b0;
    else if ((en_w_i && !line_code_ok(w_line_i)) || start_err)
      err_o <= 1'b1;
  end

  // Snapshot takes the stored line, so a same-cycle RESULT write is not seen
  npu_byte_serializer #(.RES_W(RES_W)) u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_start_i  (rd_start_i),
    .line_i      (res_q),
    .result_o    (result_o),
    .byte_idx_o  (byte_idx_o),
    .byte_vld_o  (byte_vld_o),
    .rd_done_o   (rd_done_o),
    .rd_busy_o   (rd_busy_o),
    .start_err_o (start_err)
  );

endmodule

// File: tb/tb_npu_line_store.sv
module tb_npu_line_store;
  localparam int S2_W = 6272, C3_W = 3136, S4_W = 3200, C5_W = 800, RES_W = 80;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              en_w_i = 1'b0;
  logic [3:0]        w_line_i = '0;
  logic [S2_W-1:0]   img28_data_i = '0;
  logic [C3_W-1:0]   img14_data_i = '0;
  logic [S4_W-1:0]   img10_data_i = '0;
  logic [C5_W-1:0]   img5_data_i = '0;
  logic [RES_W-1:0]  result_data_i = '0;
  logic              clr_i = 1'b0;
  logic              rd_start_i = 1'b0;
  logic [S2_W-1:0]   img28_o;
  logic [C3_W-1:0]   img14_o;
  logic [S4_W-1:0]   img10_o;
  logic [C5_W-1:0]   img5_o;
  logic [4:0]        line_vld_o;
  logic [7:0]        result_o;
  logic [3:0]        byte_idx_o;
  logic              byte_vld_o, rd_done_o, rd_busy_o, err_o;

  int checks = 0;
  int failures = 0;

  logic [S2_W-1:0]  pat_a, pat_b;
  logic [RES_W-1:0] res_seq, res_ff;

  npu_line_store dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_w_i(en_w_i), .w_line_i(w_line_i),
    .img28_data_i(img28_data_i), .img14_data_i(img14_data_i),
    .img10_data_i(img10_data_i), .img5_data_i(img5_data_i),
    .result_data_i(result_data_i), .clr_i(clr_i), .rd_start_i(rd_start_i),
    .img28_o(img28_o), .img14_o(img14_o), .img10_o(img10_o), .img5_o(img5_o),
    .line_vld_o(line_vld_o), .result_o(result_o), .byte_idx_o(byte_idx_o),
    .byte_vld_o(byte_vld_o), .rd_done_o(rd_done_o), .rd_busy_o(rd_busy_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // advance one clock, land 1 time unit after the edge
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    // put state in before reset: S2 line and a bad-code error
    rst_i = 1'b0;
    en_w_i = 1'b1; w_line_i = 4'd1; img28_data_i = pat_a; step();
    w_line_i = 4'd7; step();
    en_w_i = 1'b0;
    #2 rst_i = 1'b1; #1;  // asserted mid-cycle
    checks++;
    if (img28_o !== '0 || img14_o !== '0 || img10_o !== '0 || img5_o !== '0) begin
      failures++; $display("FAIL reset_lines: img28 nonzero=%0b, required all lines 0", |img28_o);
    end
    checks++;
    if (line_vld_o !== 5'b0) begin
      failures++; $display("FAIL reset_vld: got %b required 00000", line_vld_o);
    end
    checks++;
    if ({err_o, byte_vld_o, rd_done_o, rd_busy_o, result_o, byte_idx_o} !== '0) begin
      failures++; $display("FAIL reset_ctrl: err=%b vld=%b done=%b busy=%b res=%h idx=%0d required all 0",
        err_o, byte_vld_o, rd_done_o, rd_busy_o, result_o, byte_idx_o);
    end
    step(); rst_i = 1'b0; step();
  endtask

  task automatic test_write_s2();
    en_w_i = 1'b1; w_line_i = 4'd1; img28_data_i = pat_a; step();
    en_w_i = 1'b0; img28_data_i = '0;
    checks++;
    if (img28_o !== pat_a) begin
      failures++; $display("FAIL s2_write_a: got %h required %h", img28_o[31:0], pat_a[31:0]);
    end
    checks++;
    if (line_vld_o !== 5'b00001) begin
      failures++; $display("FAIL s2_vld: got %b required 00001", line_vld_o);
    end
    checks++;
    if (img14_o !== '0 || img10_o !== '0 || img5_o !== '0) begin
      failures++; $display("FAIL s2_others: other lines nonzero, required 0");
    end
    step();
    checks++;
    if (img28_o !== pat_a) begin
      failures++; $display("FAIL s2_hold: got %h required %h", img28_o[31:0], pat_a[31:0]);
    end
    en_w_i = 1'b1; w_line_i = 4'd1; img28_data_i = pat_b; step();
    en_w_i = 1'b0;
    checks++;
    if (img28_o !== pat_b) begin
      failures++; $display("FAIL s2_write_b: got %h required %h", img28_o[31:0], pat_b[31:0]);
    end
  endtask

  task automatic test_stream();
    en_w_i = 1'b1; w_line_i = 4'd5; result_data_i = res_seq; step();
    en_w_i = 1'b0;
    checks++;
    if (line_vld_o !== 5'b10001) begin
      failures++; $display("FAIL res_vld: got %b required 10001", line_vld_o);
    end
    rd_start_i = 1'b1; step(); rd_start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (byte_vld_o !== 1'b1 || rd_busy_o !== 1'b1 || result_o !== 8'(i) || byte_idx_o !== 4'(i)) begin
        failures++; $display("FAIL stream_byte%0d: vld=%b busy=%b res=%h idx=%0d required 1 1 %h %0d",
          i, byte_vld_o, rd_busy_o, result_o, byte_idx_o, 8'(i), i);
      end
      step();
    end
    checks++;
    if (rd_done_o !== 1'b1 || byte_vld_o !== 1'b0 || result_o !== 8'h00 || byte_idx_o !== 4'd0) begin
      failures++; $display("FAIL stream_done: done=%b vld=%b res=%h idx=%0d required 1 0 00 0",
        rd_done_o, byte_vld_o, result_o, byte_idx_o);
    end
    step();
    checks++;
    if (rd_done_o !== 1'b0 || rd_busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL stream_idle: done=%b busy=%b err=%b required 0 0 0",
        rd_done_o, rd_busy_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    rd_start_i = 1'b1; step(); rd_start_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (result_o !== 8'(i) || byte_vld_o !== 1'b1) bad++;
      if (i == 2) begin
        en_w_i = 1'b1; w_line_i = 4'd5; result_data_i = res_ff; rd_start_i = 1'b1;
      end else begin
        en_w_i = 1'b0; rd_start_i = 1'b0;
      end
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL b2b_old_bytes: %0d wrong bytes, required 0", bad);
    end
    checks++;
    if (rd_done_o !== 1'b1 || err_o !== 1'b1) begin
      failures++; $display("FAIL b2b_done_err: done=%b err=%b required 1 1", rd_done_o, err_o);
    end
    step();
    rd_start_i = 1'b1; step(); rd_start_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (result_o !== 8'hFF || byte_idx_o !== 4'(i) || byte_vld_o !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL b2b_new_bytes: %0d wrong bytes, required 0", bad);
    end
    checks++;
    if (rd_done_o !== 1'b1) begin
      failures++; $display("FAIL b2b_new_done: got %b required 1", rd_done_o);
    end
    step();
  endtask

  task automatic test_bad_code_clr();
    clr_i = 1'b1; step(); clr_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || line_vld_o !== 5'b0 || img28_o !== '0) begin
      failures++; $display("FAIL clr1: err=%b vld=%b img28nz=%b required 0 00000 0",
        err_o, line_vld_o, |img28_o);
    end
    en_w_i = 1'b1; w_line_i = 4'd7;
    img28_data_i = pat_a; img14_data_i = '1; img10_data_i = '1; img5_data_i = '1; result_data_i = '1;
    step();
    w_line_i = 4'd0; step();
    en_w_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || line_vld_o !== 5'b0) begin
      failures++; $display("FAIL badcode: err=%b vld=%b required 1 00000", err_o, line_vld_o);
    end
    checks++;
    if (img28_o !== '0 || img14_o !== '0 || img10_o !== '0 || img5_o !== '0) begin
      failures++; $display("FAIL badcode_lines: a line changed, required all 0");
    end
    // clr beats a same-cycle valid write
    clr_i = 1'b1; en_w_i = 1'b1; w_line_i = 4'd2; step();
    clr_i = 1'b0; en_w_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || line_vld_o !== 5'b0 || img14_o !== '0) begin
      failures++; $display("FAIL clr_beats_write: err=%b vld=%b img14nz=%b required 0 00000 0",
        err_o, line_vld_o, |img14_o);
    end
    // the other lines each write independently
    en_w_i = 1'b1; w_line_i = 4'd3; step();
    w_line_i = 4'd4; step();
    en_w_i = 1'b0;
    checks++;
    if (line_vld_o !== 5'b01100 || img10_o !== '1 || img5_o !== '1 || img14_o !== '0) begin
      failures++; $display("FAIL s4_c5_write: vld=%b required 01100", line_vld_o);
    end
  endtask

  task automatic test_reset_mid_stream();
    int bad;
    en_w_i = 1'b1; w_line_i = 4'd5; result_data_i = res_seq; step();
    en_w_i = 1'b0;
    rd_start_i = 1'b1; step(); rd_start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (byte_idx_o !== 4'd4 || result_o !== 8'h04) begin
      failures++; $display("FAIL mid_byte4: idx=%0d res=%h required 4 04", byte_idx_o, result_o);
    end
    #2 rst_i = 1'b1; #1;
    checks++;
    if (byte_vld_o !== 1'b0 || rd_busy_o !== 1'b0 || rd_done_o !== 1'b0 || result_o !== 8'h00) begin
      failures++; $display("FAIL mid_reset: vld=%b busy=%b done=%b res=%h required 0 0 0 00",
        byte_vld_o, rd_busy_o, rd_done_o, result_o);
    end
    step(); rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rd_done_o !== 1'b0 || byte_vld_o !== 1'b0 || rd_busy_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mid_after: %0d cycles not idle, required 0", bad);
    end
  endtask

  initial begin
    pat_a   = {196{32'hA5A5_1234}};
    pat_b   = {196{32'h0F0F_CAFE}};
    res_seq = 80'h09_08_07_06_05_04_03_02_01_00;
    res_ff  = '1;
    step(); step();
    test_reset();
    test_write_s2();
    test_stream();
    test_back_to_back();
    test_bad_code_clr();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule
